// File: rtl/mod_pkg.sv
// Shared constants and state type for the modular arithmetic blocks (Q = 8380417).
package mod_pkg;

    localparam int unsigned MOD_Q  = 8380417;
    localparam int unsigned MOD_QW = 23;
    localparam int unsigned MOD_PW = 48;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/mod_cond_sub.sv
// Final conditional subtraction: folds a residue in [0, 2^QW) with r < 2Q back into [0, Q).
module mod_cond_sub
    import mod_pkg::*;
#(
    parameter int unsigned QW = MOD_QW,
    parameter int unsigned Q  = MOD_Q
) (
    input  logic [QW-1:0] r,
    output logic [QW-1:0] y_c
);

    assign y_c = (r >= QW'(Q)) ? r - QW'(Q) : r;

endmodule

// File: rtl/mod_mul_issuer.sv
// Operand front end: multiplies an accepted pair, hands the product to the reducer,
// finishes the reduction and returns the residue downstream; watchdog on the reducer.
module mod_mul_issuer
    import mod_pkg::*;
#(
    parameter int unsigned Q       = MOD_Q,
    parameter int unsigned QW      = MOD_QW,
    parameter int unsigned PW      = MOD_PW,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] a,
    input  logic [QW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_data,
    output logic          red_start,
    output logic [PW-1:0] red_data_in,
    input  logic          red_done,
    input  logic [QW-1:0] red_data_out,
    output logic          range_err,
    output logic          timeout_err
);

    localparam int unsigned MW = 2 * QW;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_nxt;
    logic [QW-1:0] a_q;
    logic [QW-1:0] a_nxt;
    logic [QW-1:0] b_q;
    logic [QW-1:0] b_nxt;
    logic [PW-1:0] prod_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic [QW-1:0] out_data_nxt;
    logic          range_err_nxt;
    logic          timeout_err_nxt;
    logic          in_ready_nxt;
    logic          out_valid_nxt;
    logic          red_start_nxt;
    logic [MW-1:0] mul_c;
    logic [QW-1:0] red_sub_c;

    assign mul_c = MW'(a_q) * MW'(b_q);

    mod_cond_sub #(
        .QW (QW),
        .Q  (Q)
    ) u_cond_sub (
        .r   (red_data_out),
        .y_c (red_sub_c)
    );

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_nxt       = state;
        a_nxt           = a_q;
        b_nxt           = b_q;
        prod_nxt        = red_data_in;
        cnt_nxt         = cnt_q;
        out_data_nxt    = out_data;
        range_err_nxt   = range_err;
        timeout_err_nxt = timeout_err;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_nxt         = a;
                    b_nxt         = b;
                    range_err_nxt = range_err | (a >= QW'(Q)) | (b >= QW'(Q));
                    state_nxt     = MUL;
                end
            end
            MUL: begin
                prod_nxt  = PW'(mul_c);
                state_nxt = ISSUE;
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle still wins over the watchdog.
                if (red_done) begin
                    out_data_nxt = red_sub_c;
                    state_nxt    = HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_nxt = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        in_ready_nxt  = (state_nxt == IDLE);
        red_start_nxt = (state_nxt == ISSUE);
        out_valid_nxt = (state_nxt == HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            red_data_in <= '0;
            cnt_q       <= '0;
            out_data    <= '0;
            range_err   <= 1'b0;
            timeout_err <= 1'b0;
            in_ready    <= 1'b0;
            red_start   <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            a_q         <= a_nxt;
            b_q         <= b_nxt;
            red_data_in <= prod_nxt;
            cnt_q       <= cnt_nxt;
            out_data    <= out_data_nxt;
            range_err   <= range_err_nxt;
            timeout_err <= timeout_err_nxt;
            in_ready    <= in_ready_nxt;
            red_start   <= red_start_nxt;
            out_valid   <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_mod_mul_issuer.sv
// Directed and randomized checks of mod_mul_issuer against a behavioural
// (a*b) mod Q model with an in-bench reducer responder.
module tb_mod_mul_issuer;

    localparam longint unsigned Q_REF = 64'd8380417;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] a;
    logic [22:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_data;
    logic        red_start;
    logic [47:0] red_data_in;
    logic        red_done;
    logic [22:0] red_data_out;
    logic        range_err;
    logic        timeout_err;

    int          n_vec;
    int          n_err;

    // Reducer responder state
    int          red_lat;
    logic [22:0] red_bias;
    bit          red_hang;
    int          red_stale;
    bit          pend;
    int          cd;
    logic [22:0] rval;

    mod_mul_issuer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .red_start    (red_start),
        .red_data_in  (red_data_in),
        .red_done     (red_done),
        .red_data_out (red_data_out),
        .range_err    (range_err),
        .timeout_err  (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reducer: answers a start after red_lat cycles with (p mod Q) + bias.
    task automatic reducer_step();
        longint unsigned p;
        red_done = 1'b0;
        if (pend) begin
            cd--;
            if (cd <= 0) begin
                pend         = 1'b0;
                red_done     = 1'b1;
                red_data_out = rval;
            end
        end
        if (red_stale > 0) begin
            red_stale--;
            red_done     = 1'b1;
            red_data_out = 23'($urandom);
        end
        if (red_start === 1'b1 && !red_hang) begin
            p    = 64'(red_data_in);
            pend = 1'b1;
            cd   = red_lat;
            rval = 23'((p % Q_REF) + 64'(red_bias));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        reducer_step();
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("in_ready_before_op", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [22:0] oa, input logic [22:0] ob, input int lat,
                          input logic [22:0] bias, input int hold);
        longint unsigned p;
        logic [22:0]     expr;
        int              n;
        int              starts;
        bit              stable;
        p        = 64'(oa) * 64'(ob);
        expr     = 23'(p % Q_REF);
        red_lat  = lat;
        red_bias = bias;
        wait_ready();
        in_valid  = 1'b1;
        a         = oa;
        b         = ob;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        a        = 23'($urandom);
        b        = 23'($urandom);
        chk("mul_in_ready", 64'(in_ready), 64'd0);
        chk("mul_no_start", 64'(red_start), 64'd0);
        tick();
        chk("issue_start", 64'(red_start), 64'd1);
        chk("red_data_in", 64'(red_data_in), p);
        starts = 0;
        stable = 1'b1;
        n      = 0;
        while (out_valid !== 1'b1 && n < lat + 4) begin
            tick();
            n++;
            if (red_start !== 1'b0) starts++;
            if (red_data_in !== 48'(p)) stable = 1'b0;
        end
        chk("start_single_cycle", 64'(starts), 64'd0);
        chk("red_data_in_stable", 64'(stable), 64'd1);
        chk("result_latency", 64'(n), 64'(lat + 1));
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_data", 64'(out_data), 64'(expr));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = 23'($urandom);
            tick();
            if (out_valid !== 1'b1 || out_data !== expr || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) chk("hold_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("after_hs_valid", 64'(out_valid), 64'd0);
        chk("after_hs_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        bit              bad;
        logic [22:0]     ra;
        logic [22:0]     rb;
        logic [22:0]     bias;
        longint unsigned p;

        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        out_ready    = 1'b1;
        red_done     = 1'b0;
        red_data_out = '0;
        red_lat      = 1;
        red_bias     = '0;
        red_hang     = 1'b0;
        red_stale    = 0;
        pend         = 1'b0;
        cd           = 0;
        rval         = '0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_red_start", 64'(red_start), 64'd0);
        chk("rst_red_data_in", 64'(red_data_in), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_range_err", 64'(range_err), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed products
        run_op(23'd1000, 23'd1000, 3, 23'd0, 0);
        run_op(23'd8380416, 23'd8380416, 2, 23'd0, 0);
        run_op(23'd4096, 23'd2048, 2, 23'd0, 5);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (red_start !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        chk("busy_valid_not_consumed", 64'(bad), 64'd0);
        run_op(23'd5, 23'd1, 1, 23'(Q_REF), 0);

        // Randomized operands, latencies and backpressure
        for (int i = 0; i < 20; i++) begin
            ra = 23'($urandom_range(32'd8380416, 32'd0));
            rb = 23'($urandom_range(32'd8380416, 32'd0));
            if (i % 5 == 0) ra = 23'(Q_REF - 1 - 64'($urandom_range(32'd3, 32'd0)));
            if (i % 7 == 0) rb = 23'($urandom_range(32'd3, 32'd0));
            p    = 64'(ra) * 64'(rb);
            bias = '0;
            if ((p % Q_REF) < 64'd8191 && $urandom_range(32'd1, 32'd0) == 32'd1) bias = 23'(Q_REF);
            run_op(ra, rb, int'($urandom_range(32'd8, 32'd1)), bias, int'($urandom_range(32'd2, 32'd0)));
        end
        chk("range_err_clear", 64'(range_err), 64'd0);

        // Done on the watchdog's last cycle wins
        run_op(23'd77, 23'd99, 64, 23'd0, 0);
        chk("done_at_expiry_no_timeout", 64'(timeout_err), 64'd0);

        // Reducer never answers
        red_hang = 1'b1;
        wait_ready();
        in_valid = 1'b1;
        a        = 23'd11;
        b        = 23'd13;
        tick();
        in_valid = 1'b0;
        tick();
        chk("to_issue_start", 64'(red_start), 64'd1);
        bad = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        chk("to_pre_err", 64'(timeout_err), 64'd0);
        chk("to_pre_ready", 64'(in_ready), 64'd0);
        tick();
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_idle", 64'(in_ready), 64'd1);
        chk("to_no_valid", 64'(bad | out_valid), 64'd0);
        red_hang = 1'b0;
        run_op(23'd3, 23'd5, 2, 23'd0, 0);
        chk("to_sticky", 64'(timeout_err), 64'd1);

        // Out-of-range operand is flagged but still processed
        run_op(23'd8380417, 23'd2, 3, 23'd0, 0);
        chk("range_err_set", 64'(range_err), 64'd1);
        run_op(23'd12345, 23'd678, 1, 23'd0, 1);
        chk("range_err_sticky", 64'(range_err), 64'd1);

        // Reset while waiting on the reducer, then stale dones
        red_lat = 10;
        wait_ready();
        in_valid = 1'b1;
        a        = 23'd3;
        b        = 23'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n     = 1'b0;
        red_stale = 3;
        tick();
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_red_data_in", 64'(red_data_in), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_range_err", 64'(range_err), 64'd0);
        chk("midrst_timeout_err", 64'(timeout_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_after", 64'(in_ready), 64'd1);
        red_stale = 4;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0 || red_start !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        chk("stale_done_ignored", 64'(bad), 64'd0);
        run_op(23'd3, 23'd5, 2, 23'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
